// File: rtl/chip_select_responder.sv
// Target-side responder: two memory banks plus a 4-entry register file, with per-region wait states.
// Optional CSR_ACCESS_COUNT_EN makes register index 3 a read-only count of completed ACKs.
module chip_select_responder #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int WS0 = 2,
  parameter int WS1 = 4,
  parameter int WSC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memce0,
  input  logic          memce1,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic          busy
);

  if (WS0 < 0 || WS0 > 15 || WS1 < 0 || WS1 > 15 || WSC < 0 || WSC > 15) begin : g_ws_chk
    $error("chip_select_responder: wait-state parameters must be in 0..15");
  end

  localparam logic [3:0] WS0_C = WS0[3:0];
  localparam logic [3:0] WS1_C = WS1[3:0];
  localparam logic [3:0] WSC_C = WSC[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;
  typedef enum logic [1:0] {RG_B0, RG_B1, RG_CS} region_t;

  state_t        state, state_nx;
  region_t       region_q, region_sel;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt, ws_sel;
  logic          req, multi, accept, commit;
  logic [DW-1:0] rd_word, rdata_q;

  logic [DW-1:0] bank0 [2**AW];
  logic [DW-1:0] bank1 [2**AW];
  logic [DW-1:0] regs  [4];
`ifdef CSR_ACCESS_COUNT_EN
  logic [DW-1:0] acc_cnt;
`endif

  always_comb begin
    req    = memce0 | memce1 | cs;
    multi  = (memce0 & memce1) | (memce0 & cs) | (memce1 & cs);
    accept = (state == IDLE) && req && !multi;
    if (memce0) begin
      ws_sel     = WS0_C;
      region_sel = RG_B0;
    end else if (memce1) begin
      ws_sel     = WS1_C;
      region_sel = RG_B1;
    end else begin
      ws_sel     = WSC_C;
      region_sel = RG_CS;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (multi)              state_nx = ERR;
          else if (ws_sel == '0)  state_nx = ACK;
          else                    state_nx = WAIT;
        end
      end
      WAIT:    if (cnt <= 4'd1) state_nx = ACK;
      ACK:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      region_q <= region_sel;
      we_q     <= we;
      addr_q   <= addr;
      wdata_q  <= wdata;
      cnt      <= ws_sel;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Storage commits only at the end of an ACK that is not being reset away.
  assign commit = !rst && (state == ACK) && we_q;

  always_ff @(posedge clk) begin
    if (commit && region_q == RG_B0) bank0[addr_q] <= wdata_q;
    if (commit && region_q == RG_B1) bank1[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit && region_q == RG_CS) begin
`ifdef CSR_ACCESS_COUNT_EN
      if (addr_q[1:0] != 2'd3) regs[addr_q[1:0]] <= wdata_q;
`else
      regs[addr_q[1:0]] <= wdata_q;
`endif
    end
  end

`ifdef CSR_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                acc_cnt <= '0;
    else if (state == ACK)  acc_cnt <= acc_cnt + 1'b1;
  end
`endif

  always_comb begin
    rd_word = '0;
    case (region_q)
      RG_B0:   rd_word = bank0[addr_q];
      RG_B1:   rd_word = bank1[addr_q];
      RG_CS:   rd_word = regs[addr_q[1:0]];
      default: rd_word = '0;
    endcase
`ifdef CSR_ACCESS_COUNT_EN
    if (region_q == RG_CS && addr_q[1:0] == 2'd3) rd_word = acc_cnt;
`endif
  end

  // rdata shows the live word during a read ACK and holds it afterwards.
  always_ff @(posedge clk) begin
    if (rst)                             rdata_q <= '0;
    else if (state == ACK && !we_q)      rdata_q <= rd_word;
  end

  assign rdata = (state == ACK && !we_q) ? rd_word : rdata_q;
  assign ready = (state == ACK);
  assign err   = (state == ERR);
  assign busy  = (state == WAIT) || (state == ACK);

endmodule

// File: tb/tb_chip_select_responder.sv
// Directed self-checking bench for chip_select_responder (default WS0=2, WS1=4, WSC=0).
module tb_chip_select_responder;

  logic       clk = 1'b0;
  logic       rst, memce0, memce1, cs, we;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;
  logic       ready, err, busy;

  int checks   = 0;
  int failures = 0;

  chip_select_responder #(.DW(8), .AW(4), .WS0(2), .WS1(4), .WSC(0)) dut (
    .clk(clk), .rst(rst), .memce0(memce0), .memce1(memce1), .cs(cs), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; memce0 = 1'b0; memce1 = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    step; step;
    rst = 1'b0;
  endtask

  // sel = {cs, memce1, memce0}; a_after is driven onto addr once the request is accepted.
  task automatic access(input string tag, input logic [2:0] sel, input logic w,
                        input logic [3:0] a, input logic [7:0] d, input logic [3:0] a_after,
                        input int exp_lat, input logic [7:0] exp_rd);
    int lat, nbusy;
    bit saw_err;
    {cs, memce1, memce0} = sel; we = w; addr = a; wdata = d;
    step;
    {cs, memce1, memce0} = 3'b000; we = ~w; addr = a_after; wdata = '0;
    lat = 1; nbusy = 0; saw_err = 1'b0;
    while (!ready && lat <= 20) begin
      if (busy) nbusy++;
      if (err) saw_err = 1'b1;
      step;
      lat++;
    end
    if (busy) nbusy++;
    if (err) saw_err = 1'b1;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, nbusy, exp_lat);
    check({tag, " no err"}, saw_err, 0);
    if (!w) check({tag, " rdata"}, rdata, exp_rd);
    step;
    check({tag, " ready one cycle"}, ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset;
    check("reset ready", ready, 0);
    check("reset err", err, 0);
    check("reset busy", busy, 0);
    check("reset rdata", rdata, 8'h00);

    access("cs wr idx1", 3'b100, 1'b1, 4'd1, 8'hA5, 4'd1, 1, 8'h00);
    access("cs rd idx1", 3'b100, 1'b0, 4'd1, 8'h00, 4'd1, 1, 8'hA5);
    check("rdata hold", rdata, 8'hA5);

    access("b0 wr 5", 3'b001, 1'b1, 4'd5, 8'h3C, 4'd5, 3, 8'h00);
    access("b0 rd 5", 3'b001, 1'b0, 4'd5, 8'h00, 4'd5, 3, 8'h3C);

    access("b1 wr 5", 3'b010, 1'b1, 4'd5, 8'h5A, 4'd5, 5, 8'h00);
    access("b1 wr 2", 3'b010, 1'b1, 4'd2, 8'h22, 4'd2, 5, 8'h00);
    access("b1 wr 9", 3'b010, 1'b1, 4'd9, 8'h99, 4'd9, 5, 8'h00);
    access("b1 rd 2 addr moved", 3'b010, 1'b0, 4'd2, 8'h00, 4'd9, 5, 8'h22);

    // Two selects at once: err pulse at request+1, nothing written.
    memce0 = 1'b1; memce1 = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'hEE;
    step;
    memce0 = 1'b0; memce1 = 1'b0; we = 1'b0;
    check("multi err", err, 1);
    check("multi ready", ready, 0);
    step;
    check("multi err one cycle", err, 0);
    check("multi no ready", ready, 0);
    access("b0 rd 5 after err", 3'b001, 1'b0, 4'd5, 8'h00, 4'd5, 3, 8'h3C);
    access("b1 rd 5 after err", 3'b010, 1'b0, 4'd5, 8'h00, 4'd5, 5, 8'h5A);

    // Reset on the 2nd WAIT cycle of a bank1 write aborts it.
    access("b1 wr 7", 3'b010, 1'b1, 4'd7, 8'h11, 4'd7, 5, 8'h00);
    memce1 = 1'b1; we = 1'b1; addr = 4'd7; wdata = 8'h99;
    step;
    memce1 = 1'b0; we = 1'b0;
    check("abort wait1 busy", busy, 1);
    step;
    check("abort wait2 ready", ready, 0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort idle busy", busy, 0);
    check("abort no ready", ready, 0);
    check("abort no err", err, 0);
    check("abort rdata cleared", rdata, 8'h00);
    access("b1 rd 7 after abort", 3'b010, 1'b0, 4'd7, 8'h00, 4'd7, 5, 8'h11);
    access("cs rd idx1 after rst", 3'b100, 1'b0, 4'd1, 8'h00, 4'd1, 1, 8'h00);

`ifdef CSR_ACCESS_COUNT_EN
    do_reset;
    access("cnt wr idx0", 3'b100, 1'b1, 4'd0, 8'h01, 4'd0, 1, 8'h00);
    access("cnt rd idx0", 3'b100, 1'b0, 4'd0, 8'h00, 4'd0, 1, 8'h01);
    access("cnt b0 rd 5", 3'b001, 1'b0, 4'd5, 8'h00, 4'd5, 3, 8'h3C);
    access("cnt rd idx3", 3'b100, 1'b0, 4'd3, 8'h00, 4'd3, 1, 8'h03);
    // The discarded write still completes an ACK, so the counter reads 5 next.
    access("cnt wr idx3", 3'b100, 1'b1, 4'd3, 8'hFF, 4'd3, 1, 8'h00);
    access("cnt rerd idx3", 3'b100, 1'b0, 4'd3, 8'h00, 4'd3, 1, 8'h05);
`else
    access("cs wr idx3", 3'b100, 1'b1, 4'd3, 8'h77, 4'd3, 1, 8'h00);
    access("cs rd idx3", 3'b100, 1'b0, 4'd3, 8'h00, 4'd3, 1, 8'h77);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
